sudoku_grid_render_ctrl: RTL



---
 rtl/sudoku_grid_render_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sudoku_grid_render_ctrl.sv
// Sudoku board store and glyph pixel sequencer.
// Decodes h_cnt/v_cnt into a 9x9 cell index plus local glyph coordinates,
// owns the 81-entry digit store and shares its single port between display
// reads, a clear sweep and external cell writes.
module sudoku_grid_render_ctrl #(
  parameter int CELL    = 52,
  parameter int GRID_X0 = 86,
  parameter int GRID_Y0 = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       clr_req,
  output logic       clr_busy,
  input  logic       wr_req,
  input  logic [3:0] wr_row,
  input  logic [3:0] wr_col,
  input  logic [3:0] wr_digit,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       glyph_valid,
  output logic [3:0] glyph_digit,
  output logic [5:0] glyph_x,
  output logic [5:0] glyph_y
);

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;

  state_t     state;
  logic [6:0] idx_clr;

  logic [3:0] board [81];
  logic [3:0] rd_data;

  logic [9:0] dx, dy, col_base, row_base;
  logic [3:0] col, row;
  logic       in_grid;
  logic [5:0] lx, ly;
  logic [6:0] idx;

  logic       in_grid_s1;
  logic [5:0] lx_s1, ly_s1;

  logic       wr_ok;
  logic [6:0] wr_idx;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [3:0] mem_wdata;

  // Stage-0 pixel decode: compare chains against multiples of CELL, no divider
  always_comb begin
    dx       = h_cnt - 10'(GRID_X0);
    dy       = v_cnt - 10'(GRID_Y0);
    in_grid  = (h_cnt >= 10'(GRID_X0)) && (h_cnt < 10'(GRID_X0 + 9*CELL)) &&
               (v_cnt >= 10'(GRID_Y0)) && (v_cnt < 10'(GRID_Y0 + 9*CELL));
    col      = '0;
    row      = '0;
    col_base = '0;
    row_base = '0;
    for (int unsigned k = 1; k < 9; k++) begin
      if (dx >= 10'(k*CELL)) begin
        col      = 4'(k);
        col_base = 10'(k*CELL);
      end
      if (dy >= 10'(k*CELL)) begin
        row      = 4'(k);
        row_base = 10'(k*CELL);
      end
    end
    lx  = 6'(dx - col_base);
    ly  = 6'(dy - row_base);
    idx = 7'(row) * 7'd9 + 7'(col);
  end

  // Board-port arbitration: display read, then clear sweep, then external write
  always_comb begin
    wr_ok     = (wr_row <= 4'd8) && (wr_col <= 4'd8) && (wr_digit <= 4'd9);
    wr_idx    = 7'(wr_row) * 7'd9 + 7'(wr_col);
    mem_we    = 1'b0;
    mem_addr  = idx;
    mem_wdata = '0;
    if (rst_n && !in_grid) begin
      if (state == CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = idx_clr;
      end else if (state == WRITE && wr_ok) begin
        mem_we    = 1'b1;
        mem_addr  = wr_idx;
        mem_wdata = wr_digit;
      end
    end
  end

  // Single-port board store with synchronous read; contents are never reset
  always_ff @(posedge clk) begin
    if (mem_we) board[mem_addr] <= mem_wdata;
    else        rd_data         <= board[mem_addr];
  end

  // Display pipeline: stage 1 holds coordinates alongside the read, stage 2 drives outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_grid_s1  <= 1'b0;
      lx_s1       <= '0;
      ly_s1       <= '0;
      glyph_valid <= 1'b0;
      glyph_digit <= '0;
      glyph_x     <= '0;
      glyph_y     <= '0;
    end else begin
      in_grid_s1  <= in_grid;
      lx_s1       <= in_grid ? lx : '0;
      ly_s1       <= in_grid ? ly : '0;
      glyph_valid <= in_grid_s1 && (rd_data != 4'd0);
      glyph_digit <= in_grid_s1 ? rd_data : '0;
      glyph_x     <= lx_s1;
      glyph_y     <= ly_s1;
    end
  end

  // Control FSM: clear sweep and write handshake, registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      idx_clr  <= '0;
      clr_busy <= 1'b1;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_req) begin
            idx_clr <= '0;
          end else if (!in_grid) begin
            if (idx_clr == 7'd80) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
            end else begin
              idx_clr <= idx_clr + 7'd1;
            end
          end
        end
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            idx_clr  <= '0;
            clr_busy <= 1'b1;
          end else if (wr_req) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (!wr_ok) begin
            wr_ack <= 1'b1;
            wr_err <= 1'b1;
            state  <= IDLE;
          end else if (!in_grid) begin
            wr_ack <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state    <= CLEAR;
          idx_clr  <= '0;
          clr_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule
